// File: rtl/gray_cnt_pkg.sv
// ---------------------------------------------------------------------------
// gray_cnt_pkg
//   Shared types, default sizes and helper functions for the cascaded
//   Gray-coded up/down counter (gray_digit, gray_updown_counter_n).
//
//   Helpers operate on a MAX_DIGIT_W-wide container so a single function
//   serves every digit width; callers zero-extend their digit and pass the
//   real width where it matters.
// ---------------------------------------------------------------------------
package gray_cnt_pkg;

    localparam int DIGITS_DEF  = 2;
    localparam int DIGIT_W_DEF = 4;
    localparam int W           = DIGITS_DEF * DIGIT_W_DEF;
    localparam int MAX_DIGIT_W = 32;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Reflected binary code of one digit: each bit XORed with its upper
    // neighbour. Zero-extended inputs stay zero-extended on output.
    function automatic logic [MAX_DIGIT_W-1:0] bin2gray(
        input logic [MAX_DIGIT_W-1:0] value
    );
        return value ^ (value >> 1);
    endfunction

    // A digit is terminal when the next step in the current direction would
    // roll it over: all-ones counting up, all-zeros counting down. Only the
    // low 'width' bits are considered.
    function automatic logic is_terminal(
        input logic [MAX_DIGIT_W-1:0] value,
        input logic                   dir,
        input int unsigned            width
    );
        logic [MAX_DIGIT_W-1:0] mask;
        mask = {MAX_DIGIT_W{1'b1}} >> (MAX_DIGIT_W - int'(width));
        if (dir == DIR_UP)
            return (value & mask) == mask;
        else
            return (value & mask) == '0;
    endfunction

endpackage

// File: rtl/gray_cnt_digit.sv
// ---------------------------------------------------------------------------
// gray_digit
//   One DIGIT_W-bit binary counter digit with per-digit Gray output.
//
//   Ports
//     clk       in   clock, rising edge
//     rst_n     in   asynchronous active-low reset, clears the digit
//     step      in   advance one count in direction dir this cycle
//     dir       in   1 = up, 0 = down
//     load      in   synchronous load of load_val, overrides step
//     load_val  in   value to load
//     hold_sat  in   suppress step (whole counter saturated at terminal)
//     b         out  registered binary digit value
//     g         out  Gray code of b (combinational)
//     term      out  digit is terminal in the current direction
// ---------------------------------------------------------------------------
module gray_digit
    import gray_cnt_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step,
    input  logic               dir,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               hold_sat,
    output logic [DIGIT_W-1:0] b,
    output logic [DIGIT_W-1:0] g,
    output logic               term
);

    logic [MAX_DIGIT_W-1:0] b_ext;

    // NOTE: every variable written in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        b_ext              = '0;
        b_ext[DIGIT_W-1:0] = b;
    end

    assign g    = DIGIT_W'(bin2gray(b_ext));
    assign term = is_terminal(b_ext, dir, DIGIT_W);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block evaluation order.
    // The reset is asynchronous: the digit clears the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b <= '0;
        end else if (load) begin
            b <= load_val;
        end else if (step && !hold_sat) begin
            // Natural modulo-2^DIGIT_W wrap provides the digit rollover.
            b <= (dir == DIR_UP) ? b + 1'b1 : b - 1'b1;
        end
    end

endmodule

// File: rtl/gray_updown_counter_n.sv
// ---------------------------------------------------------------------------
// gray_updown_counter_n
//   DIGITS cascaded DIGIT_W-bit up/down counter digits with per-digit Gray
//   output, parallel load, wrap/saturate mode and registered overflow pulse.
//
//   Ports
//     clk       in   clock, all state updates on the rising edge
//     rst_n     in   asynchronous active-low reset
//     en        in   count enable, one step per enabled cycle
//     dir       in   1 = up, 0 = down (takes effect on the same edge)
//     load      in   synchronous parallel load, priority over en
//     load_val  in   binary value to load (digit 0 in the low bits)
//     bin       out  registered binary count
//     gray      out  per-digit Gray code of bin
//     cout      out  all digits terminal in the current direction
//     ovf       out  one-cycle pulse after an enabled step at terminal count
// ---------------------------------------------------------------------------
module gray_updown_counter_n
    import gray_cnt_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int DIGIT_W = 4,
    parameter bit WRAP    = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       dir,
    input  logic                       load,
    input  logic [DIGITS*DIGIT_W-1:0]  load_val,
    output logic [DIGITS*DIGIT_W-1:0]  bin,
    output logic [DIGITS*DIGIT_W-1:0]  gray,
    output logic                       cout,
    output logic                       ovf
);

    logic [DIGIT_W-1:0] b_arr [DIGITS];
    logic [DIGIT_W-1:0] g_arr [DIGITS];
    logic [DIGITS-1:0]  term;
    logic [DIGITS-1:0]  step;
    logic               hold_sat;

    // Carry-enable chain: a digit steps only when every digit below it is
    // terminal. A running AND keeps the chain free of self-referencing bits.
    always_comb begin
        logic run;
        step = '0;
        run  = en;
        for (int d = 0; d < DIGITS; d++) begin
            step[d] = run;
            run     = run & term[d];
        end
    end

    assign cout = &term;

    // In saturate mode the whole word freezes at the terminal count; without
    // this the chain would roll every digit over exactly as in wrap mode.
    assign hold_sat = !WRAP && cout;

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        gray_digit #(
            .DIGIT_W (DIGIT_W)
        ) u_digit (
            .clk      (clk),
            .rst_n    (rst_n),
            .step     (step[d]),
            .dir      (dir),
            .load     (load),
            .load_val (load_val[d*DIGIT_W +: DIGIT_W]),
            .hold_sat (hold_sat),
            .b        (b_arr[d]),
            .g        (g_arr[d]),
            .term     (term[d])
        );
    end

    always_comb begin
        bin  = '0;
        gray = '0;
        for (int d = 0; d < DIGITS; d++) begin
            bin[d*DIGIT_W +: DIGIT_W]  = b_arr[d];
            gray[d*DIGIT_W +: DIGIT_W] = g_arr[d];
        end
    end

    // Overflow is the enabled step taken while the full word is terminal;
    // a load in the same cycle cancels it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf <= 1'b0;
        else
            ovf <= en && !load && cout;
    end

endmodule

// File: tb/tb_gray_updown_counter_n.sv
// ---------------------------------------------------------------------------
// tb_gray_updown_counter_n
//   Directed bench for gray_updown_counter_n with DIGITS=2, DIGIT_W=4.
//   Two instances share stimulus: u_wrap (WRAP=1) and u_sat (WRAP=0).
//   Inputs change and outputs are sampled 1 time unit after a rising edge.
// ---------------------------------------------------------------------------
module tb_gray_updown_counter_n;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       dir;
    logic       load;
    logic [7:0] load_val;

    logic [7:0] bin_w, gray_w, bin_s, gray_s;
    logic       cout_w, ovf_w, cout_s, ovf_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_updown_counter_n #(.DIGITS(2), .DIGIT_W(4), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .bin(bin_w), .gray(gray_w), .cout(cout_w), .ovf(ovf_w)
    );

    gray_updown_counter_n #(.DIGITS(2), .DIGIT_W(4), .WRAP(1'b0)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .bin(bin_s), .gray(gray_s), .cout(cout_s), .ovf(ovf_s)
    );

    // Advance one clock edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        en       = 1'b0;
        load_val = v;
        tick();
        load     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = 8'h00;
        #12;
        checks++; if (bin_w !== 8'h00) begin errors++; $display("FAIL reset_bin got=%h exp=00", bin_w); end
        checks++; if (gray_w !== 8'h00) begin errors++; $display("FAIL reset_gray got=%h exp=00", gray_w); end
        checks++; if (ovf_w !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf_w); end
        checks++; if (cout_w !== 1'b1) begin errors++; $display("FAIL reset_cout_down got=%b exp=1", cout_w); end
        dir = 1'b1;
        #1;
        checks++; if (cout_w !== 1'b0) begin errors++; $display("FAIL reset_cout_up got=%b exp=0", cout_w); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_up_count();
        en = 1'b1; dir = 1'b1;
        tick();
        checks++; if (bin_w !== 8'h01) begin errors++; $display("FAIL up1_bin got=%h exp=01", bin_w); end
        checks++; if (gray_w !== 8'h01) begin errors++; $display("FAIL up1_gray got=%h exp=01", gray_w); end
        for (int i = 2; i <= 16; i++) begin
            tick();
            checks++; if (cout_w !== 1'b0) begin errors++; $display("FAIL up_cout step=%0d got=%b exp=0", i, cout_w); end
        end
        checks++; if (bin_w !== 8'h10) begin errors++; $display("FAIL up16_bin got=%h exp=10", bin_w); end
        checks++; if (gray_w !== 8'h10) begin errors++; $display("FAIL up16_gray got=%h exp=10", gray_w); end
        en = 1'b0;
        tick();
        checks++; if (bin_w !== 8'h10) begin errors++; $display("FAIL hold_bin got=%h exp=10", bin_w); end
    endtask

    task automatic test_wrap_up();
        dir = 1'b1;
        do_load(8'hFF);
        checks++; if (cout_w !== 1'b1) begin errors++; $display("FAIL wrapup_cout got=%b exp=1", cout_w); end
        checks++; if (gray_w !== 8'h88) begin errors++; $display("FAIL wrapup_gray_ff got=%h exp=88", gray_w); end
        checks++; if (ovf_w !== 1'b0) begin errors++; $display("FAIL wrapup_ovf_load got=%b exp=0", ovf_w); end
        en = 1'b1;
        tick();
        en = 1'b0;
        checks++; if (bin_w !== 8'h00) begin errors++; $display("FAIL wrapup_bin got=%h exp=00", bin_w); end
        checks++; if (gray_w !== 8'h00) begin errors++; $display("FAIL wrapup_gray got=%h exp=00", gray_w); end
        checks++; if (ovf_w !== 1'b1) begin errors++; $display("FAIL wrapup_ovf got=%b exp=1", ovf_w); end
        tick();
        checks++; if (ovf_w !== 1'b0) begin errors++; $display("FAIL wrapup_ovf_clear got=%b exp=0", ovf_w); end
    endtask

    task automatic test_wrap_down();
        @(negedge clk);
        rst_n = 1'b0; dir = 1'b0; en = 1'b0;
        #1;
        checks++; if (cout_w !== 1'b1) begin errors++; $display("FAIL wrapdn_cout got=%b exp=1", cout_w); end
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1;
        tick();
        checks++; if (bin_w !== 8'hFF) begin errors++; $display("FAIL wrapdn_bin got=%h exp=ff", bin_w); end
        checks++; if (gray_w !== 8'h88) begin errors++; $display("FAIL wrapdn_gray got=%h exp=88", gray_w); end
        checks++; if (ovf_w !== 1'b1) begin errors++; $display("FAIL wrapdn_ovf got=%b exp=1", ovf_w); end
        tick();
        en = 1'b0;
        checks++; if (bin_w !== 8'hFE) begin errors++; $display("FAIL wrapdn2_bin got=%h exp=fe", bin_w); end
        checks++; if (gray_w !== 8'h89) begin errors++; $display("FAIL wrapdn2_gray got=%h exp=89", gray_w); end
        checks++; if (ovf_w !== 1'b0) begin errors++; $display("FAIL wrapdn2_ovf got=%b exp=0", ovf_w); end
        // Borrow across the digit boundary: 10 -> 0F.
        do_load(8'h10);
        en = 1'b1;
        tick();
        en = 1'b0;
        checks++; if (bin_w !== 8'h0F) begin errors++; $display("FAIL borrow_bin got=%h exp=0f", bin_w); end
    endtask

    task automatic test_saturate();
        dir = 1'b1;
        do_load(8'hFF);
        en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (bin_s !== 8'hFF) begin errors++; $display("FAIL sat_bin cyc=%0d got=%h exp=ff", i, bin_s); end
            checks++; if (ovf_s !== 1'b1) begin errors++; $display("FAIL sat_ovf cyc=%0d got=%b exp=1", i, ovf_s); end
        end
        en = 1'b0;
        tick();
        checks++; if (ovf_s !== 1'b0) begin errors++; $display("FAIL sat_ovf_clear got=%b exp=0", ovf_s); end
        // Saturate going down at zero.
        dir = 1'b0;
        do_load(8'h00);
        en = 1'b1;
        tick();
        en = 1'b0;
        checks++; if (bin_s !== 8'h00) begin errors++; $display("FAIL satdn_bin got=%h exp=00", bin_s); end
        checks++; if (ovf_s !== 1'b1) begin errors++; $display("FAIL satdn_ovf got=%b exp=1", ovf_s); end
    endtask

    task automatic test_load_priority();
        dir = 1'b1;
        do_load(8'hFF);
        // Counter terminal, en asserted, but load wins and suppresses ovf.
        load = 1'b1; en = 1'b1; load_val = 8'h5A;
        tick();
        load = 1'b0; en = 1'b0;
        checks++; if (bin_w !== 8'h5A) begin errors++; $display("FAIL ldpri_bin got=%h exp=5a", bin_w); end
        checks++; if (gray_w !== 8'h7F) begin errors++; $display("FAIL ldpri_gray got=%h exp=7f", gray_w); end
        checks++; if (ovf_w !== 1'b0) begin errors++; $display("FAIL ldpri_ovf got=%b exp=0", ovf_w); end
        checks++; if (ovf_s !== 1'b0) begin errors++; $display("FAIL ldpri_ovf_sat got=%b exp=0", ovf_s); end
    endtask

    task automatic test_async_reset();
        dir = 1'b1;
        do_load(8'hFF);
        // Make ovf high so the asynchronous clear is observable on it too.
        en = 1'b1;
        tick();
        en = 1'b0;
        do_load(8'h36);
        en = 1'b1;
        tick();
        en = 1'b0;
        checks++; if (bin_w !== 8'h37) begin errors++; $display("FAIL prerst_bin got=%h exp=37", bin_w); end
        do_load(8'hFF);
        en = 1'b1;
        tick();
        checks++; if (ovf_s !== 1'b1) begin errors++; $display("FAIL prerst_ovf got=%b exp=1", ovf_s); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bin_s !== 8'h00) begin errors++; $display("FAIL arst_bin got=%h exp=00", bin_s); end
        checks++; if (ovf_s !== 1'b0) begin errors++; $display("FAIL arst_ovf got=%b exp=0", ovf_s); end
        #2;
        rst_n = 1'b1;
        tick();
        en = 1'b0;
        checks++; if (bin_w !== 8'h01) begin errors++; $display("FAIL arst_resume got=%h exp=01", bin_w); end
        checks++; if (bin_s !== 8'h01) begin errors++; $display("FAIL arst_resume_sat got=%h exp=01", bin_s); end
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_load_priority();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
